// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end: FSM state encoding,
// command opcodes and default word/data widths.
package spi_pkg;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_if.sv
// Pad-side SPI pins plus the RAM-side word/read-data port of the SPI slave.
// rx_valid is a one-cycle strobe with no back-pressure (rx_data valid only
// while it is high); tx_valid/tx_data are sampled only while a read-data
// command is waiting for its byte, and ignored at any other time.
interface spi_if #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8
);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave: assembles MSB-first command words from MOSI and shifts RAM read
// data out on MISO. Optional macro SPI_RD_ADDR_CHECK_EN drops read-data words without a prior read address.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WORD_W = spi_pkg::WORD_W,
    parameter int DATA_W = spi_pkg::DATA_W
) (
    input  logic       clk,
    input  logic       rst,
    spi_if.slave       bus,
    output spi_state_e state,
    output logic       rd_addr_ok
);

    localparam logic [3:0] LAST_BIT  = 4'(WORD_W - 1);
    localparam logic [3:0] WORD_CNT  = 4'(WORD_W);
    localparam logic [3:0] OUT_START = 4'(DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [WORD_W-2:0] shift_q;
    logic [3:0]        bit_cnt_q;
    logic              rd_addr_ok_q;
    logic [WORD_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              miso_q;
    logic [DATA_W-1:0] out_sr_q;
    logic [3:0]        out_cnt_q;
    logic              tx_wait_q;

    logic              sample_bit;
    logic              word_done;
    logic              emit;
    logic              start_readout;
    logic [WORD_W-1:0] word_next;
    logic [1:0]        opcode;

    assign word_next = {shift_q, bus.MOSI};
    assign opcode    = word_next[WORD_W-1 -: 2];

    always_comb begin
        state_d       = state_q;
        sample_bit    = 1'b0;
        word_done     = 1'b0;
        emit          = 1'b0;
        start_readout = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                sample_bit = 1'b1;
                if (!bus.MOSI)         state_d = WRITE;
                else if (rd_addr_ok_q) state_d = READ_DATA;
                else                   state_d = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                // Once the word is complete the counter parks at WORD_CNT and MOSI is ignored.
                if (bit_cnt_q < WORD_CNT) begin
                    sample_bit = 1'b1;
                    word_done  = (bit_cnt_q == LAST_BIT);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && bus.SS_n) begin
            state_d    = IDLE;
            sample_bit = 1'b0;
            word_done  = 1'b0;
        end

`ifdef SPI_RD_ADDR_CHECK_EN
        emit = word_done && !(opcode == OP_RD_DATA && !rd_addr_ok_q);
`else
        emit = word_done;
`endif
        // Only the path entered with a valid read address actually reads RAM data back.
        start_readout = emit && (state_q == READ_DATA) && (opcode == OP_RD_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            rd_addr_ok_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            miso_q       <= 1'b0;
            out_sr_q     <= '0;
            out_cnt_q    <= '0;
            tx_wait_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= emit;

            if (emit) begin
                rx_data_q <= word_next;
                if (opcode == OP_RD_ADDR)      rd_addr_ok_q <= 1'b1;
                else if (opcode == OP_RD_DATA) rd_addr_ok_q <= 1'b0;
            end

            if (state_d == IDLE) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
                out_sr_q  <= '0;
                out_cnt_q <= '0;
                tx_wait_q <= 1'b0;
            end else begin
                if (sample_bit) begin
                    shift_q   <= word_next[WORD_W-2:0];
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end

                if (start_readout) begin
                    tx_wait_q <= 1'b1;
                end else if (tx_wait_q && bus.tx_valid) begin
                    // MSB goes straight to MISO on the capture edge; the rest queue behind it.
                    miso_q    <= bus.tx_data[DATA_W-1];
                    out_sr_q  <= {bus.tx_data[DATA_W-2:0], 1'b0};
                    out_cnt_q <= OUT_START;
                    tx_wait_q <= 1'b0;
                end else if (out_cnt_q != 4'd0) begin
                    miso_q    <= out_sr_q[DATA_W-1];
                    out_sr_q  <= {out_sr_q[DATA_W-2:0], 1'b0};
                    out_cnt_q <= out_cnt_q - 4'd1;
                end else begin
                    miso_q <= 1'b0;
                end
            end
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign state        = state_q;
    assign rd_addr_ok   = rd_addr_ok_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frame table, hand-written abort/reset
// sequences, then randomized frames scored against a rule-level model.
module tb_spi_slave;
    import spi_pkg::*;

`ifdef SPI_RD_ADDR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic       clk;
    logic       rst;
    spi_state_e state;
    logic       rd_addr_ok;

    spi_if #(.WORD_W(10), .DATA_W(8)) bus ();

    spi_slave #(.WORD_W(10), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .state      (state),
        .rd_addr_ok (rd_addr_ok)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_vec = 0;
    int n_err = 0;
    bit m_ok  = 1'b0;
    logic [9:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_ok = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- reference model ----------------
    // Readout only happens for an opcode-11 word that found the read address already set.
    task automatic model_word(input logic [9:0] w, output bit emit, output bit rd);
        logic [1:0] op;
        op   = w[9:8];
        rd   = (op == 2'b11) && m_ok;
        emit = !(CHECK && op == 2'b11 && !m_ok);
        if (emit && op == 2'b10)      m_ok = 1'b1;
        else if (emit && op == 2'b11) m_ok = 1'b0;
    endtask

    // ---------------- drivers ----------------
    task automatic frame(input logic [9:0] w, input logic [7:0] ram, input bit full,
                         input bit exp_emit, input logic [7:0] exp_byte, input bit exp_ok);
        bit early;
        bit stray;
        bit ram_answer;
        logic [7:0] got;
        int hold;
        early = 1'b0;
        stray = 1'b0;
        if (exp_emit) exp_q.push_back(w);
        bus.SS_n     = 1'b0;
        bus.MOSI     = 1'($urandom_range(0, 1));
        bus.tx_valid = 1'($urandom_range(0, 1));
        bus.tx_data  = 8'($urandom);
        tick();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI     = w[i];
            bus.tx_valid = 1'($urandom_range(0, 1));
            tick();
            if (i > 0 && bus.rx_valid) early = 1'b1;
            if (bus.MISO) stray = 1'b1;
        end
        bus.tx_valid = 1'b0;
        chk("rx_valid_early", 32'(early), 32'd0);
        chk("rx_valid", 32'(bus.rx_valid), 32'(exp_emit));
        if (bus.rx_valid) begin
            if (exp_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
            else                   chk("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
        end
        ram_answer = bus.rx_valid && (bus.rx_data[9:8] == 2'b11);
        if (!full) begin
            bus.SS_n = 1'b1;
            tick();
            chk("short_rx_valid_off", 32'(bus.rx_valid), 32'd0);
            chk("short_state", 32'(state), 32'(IDLE));
            chk("short_rd_addr_ok", 32'(rd_addr_ok), 32'(exp_ok));
            return;
        end
        bus.MOSI = 1'($urandom_range(0, 1));
        tick();
        chk("rx_valid_width", 32'(bus.rx_valid), 32'd0);
        if (bus.MISO) stray = 1'b1;
        if (ram_answer) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = ram;
        end
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        got[7] = bus.MISO;
        for (int b = 6; b >= 0; b--) begin
            bus.MOSI     = 1'($urandom_range(0, 1));
            bus.tx_valid = 1'($urandom_range(0, 1));
            tick();
            got[b] = bus.MISO;
        end
        chk("miso_byte", 32'(got), 32'(exp_byte));
        hold = $urandom_range(1, 4);
        for (int h = 0; h < hold; h++) begin
            bus.MOSI     = 1'($urandom_range(0, 1));
            bus.tx_valid = 1'($urandom_range(0, 1));
            tick();
            if (bus.MISO || bus.rx_valid) stray = 1'b1;
        end
        chk("miso_quiet", 32'(stray), 32'd0);
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'b0;
        tick();
        chk("end_state", 32'(state), 32'(IDLE));
        chk("end_miso", 32'(bus.MISO), 32'd0);
        chk("rd_addr_ok", 32'(rd_addr_ok), 32'(exp_ok));
    endtask

    task automatic abort_frame(input logic [9:0] w, input int nbits);
        bit seen;
        seen = 1'b0;
        bus.SS_n = 1'b0;
        tick();
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = w[9-i];
            tick();
            if (bus.rx_valid) seen = 1'b1;
        end
        bus.SS_n = 1'b1;
        bus.MOSI = 1'($urandom_range(0, 1));
        tick();
        if (bus.rx_valid) seen = 1'b1;
        chk("abort_rx_valid", 32'(seen), 32'd0);
        chk("abort_state", 32'(state), 32'(IDLE));
        chk("abort_miso", 32'(bus.MISO), 32'd0);
        chk("abort_rd_addr_ok", 32'(rd_addr_ok), 32'(m_ok));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [9:0] word;
        logic [7:0] ram;
        bit         exp_emit;
        logic [7:0] exp_byte;
        bit         exp_ok;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit e;
        bit r;
        bit full;
        int kind;
        logic [9:0] w;
        logic [7:0] ram;

        vecs[0] = '{10'h0FE, 8'h00, 1'b1,   8'h00, 1'b0};
        vecs[1] = '{10'h1AA, 8'h00, 1'b1,   8'h00, 1'b0};
        vecs[2] = '{10'h2FE, 8'h00, 1'b1,   8'h00, 1'b1};
        vecs[3] = '{10'h3A5, 8'h5C, 1'b1,   8'h5C, 1'b0};
        vecs[4] = '{10'h233, 8'h00, 1'b1,   8'h00, 1'b1};
        vecs[5] = '{10'h244, 8'h99, 1'b1,   8'h00, 1'b1};
        vecs[6] = '{10'h300, 8'hC3, 1'b1,   8'hC3, 1'b0};
        vecs[7] = '{10'h311, 8'h77, !CHECK, 8'h00, 1'b0};
        vecs[8] = '{10'h155, 8'h00, 1'b1,   8'h00, 1'b0};

        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        apply_reset();
        chk("reset_state", 32'(state), 32'(IDLE));
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
        chk("reset_miso", 32'(bus.MISO), 32'd0);
        chk("reset_rd_addr_ok", 32'(rd_addr_ok), 32'd0);

        for (int i = 0; i < 9; i++) begin
            model_word(vecs[i].word, e, r);
            frame(vecs[i].word, vecs[i].ram, 1'b1, vecs[i].exp_emit, vecs[i].exp_byte, vecs[i].exp_ok);
        end

        // Abort after 5 bits of 0x1AA, then a clean frame starts with no gap.
        abort_frame(10'h1AA, 5);
        frame(10'h155, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);

        // SS_n rising together with rx_valid still delivers the word.
        model_word(10'h2C8, e, r);
        frame(10'h2C8, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);
        model_word(10'h10F, e, r);
        frame(10'h10F, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);

        // Read-data frame straight after reset.
        apply_reset();
        model_word(10'h33C, e, r);
        frame(10'h33C, 8'hE7, 1'b1, !CHECK, 8'h00, 1'b0);

        // Reset in the middle of a frame clears a set read address.
        model_word(10'h2AB, e, r);
        frame(10'h2AB, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
        bus.SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 6; i--) begin
            bus.MOSI = 10'h0F0 >> i;
            tick();
        end
        rst = 1'b1;
        tick();
        chk("midframe_rst_state", 32'(state), 32'(IDLE));
        chk("midframe_rst_ok", 32'(rd_addr_ok), 32'd0);
        rst = 1'b0;
        bus.SS_n = 1'b1;
        m_ok = 1'b0;
        tick();

        // Reset during MISO readout at bit 4.
        model_word(10'h25A, e, r);
        frame(10'h25A, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
        model_word(10'h3C7, e, r);
        exp_q.push_back(10'h3C7);
        bus.SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = 10'h3C7 >> i;
            tick();
        end
        chk("rd_rx_valid", 32'(bus.rx_valid), 32'd1);
        if (exp_q.size() != 0) chk("rd_rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
        tick();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA9;
        tick();
        bus.tx_valid = 1'b0;
        chk("rd_bit7", 32'(bus.MISO), 32'd1);
        tick();
        chk("rd_bit6", 32'(bus.MISO), 32'd0);
        tick();
        chk("rd_bit5", 32'(bus.MISO), 32'd1);
        tick();
        chk("rd_bit4", 32'(bus.MISO), 32'd0);
        rst = 1'b1;
        tick();
        chk("readout_rst_miso", 32'(bus.MISO), 32'd0);
        chk("readout_rst_state", 32'(state), 32'(IDLE));
        chk("readout_rst_ok", 32'(rd_addr_ok), 32'd0);
        chk("readout_rst_rx_data", 32'(bus.rx_data), 32'd0);
        rst = 1'b0;
        bus.SS_n = 1'b1;
        m_ok = 1'b0;
        tick();

        // ---------------- randomized frames ----------------
        for (int i = 0; i < 60; i++) begin
            w = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0) w[9] = 1'b1;
            ram  = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                abort_frame(w, $urandom_range(0, 9));
            end else begin
                model_word(w, e, r);
                full = !(kind < 4 && w[9:8] != 2'b11);
                frame(w, ram, full, e, r ? ram : 8'h00, m_ok);
            end
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave front end for the single-port RAM. It samples MOSI one bit per `clk` cycle while `SS_n` is low, assembles 10-bit command words (2-bit opcode + 8-bit payload) and presents each word on `rx_data` with a one-cycle `rx_valid` strobe. For read-data commands it captures the RAM's `tx_data`/`tx_valid` response and shifts it out MSB-first on MISO. It sits between the pad-level SPI pins and the RAM's `din`/`rx_valid`/`dout`/`tx_valid` port.

## Interface
- `WORD_W`, 10: command word width (opcode + payload).
- `DATA_W`, 8: RAM read-data width.
- `clk`  in  1: single clock. MOSI/SS_n are sampled on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `SS_n`  in  1: slave select, active low.
- `MOSI`  in  1: serial data in, MSB first.
- `MISO`  out  1: serial data out, MSB first.
- `rx_data`  out  WORD_W: assembled command word; opcode in [9:8].
- `rx_valid`  out  1: one-cycle strobe; `rx_data` is valid while it is high.
- `tx_data`  in  DATA_W: read data from RAM.
- `tx_valid`  in  1: `tx_data` is valid.

## Operation
- Opcodes:
  - 00 = write address.
  - 01 = write data.
  - 10 = read address.
  - 11 = read data.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: `SS_n`=0 -> CHK_CMD. No bit is sampled in this cycle.
- CHK_CMD: samples MOSI as bit 9 and shifts it in.
  - MOSI=0 -> WRITE.
  - MOSI=1 and `rd_addr_ok`=0 -> READ_ADD.
  - MOSI=1 and `rd_addr_ok`=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in bits 8..0, one per cycle, tracked by a 4-bit counter.
- After the 10th bit: `rx_data` is loaded and `rx_valid` pulses.
  - WRITE and READ_ADD then idle in state, ignoring MOSI until `SS_n`=1.
- `rd_addr_ok` flag update:
  - Set when a word with opcode 10 is emitted.
  - Cleared when a word with opcode 11 is emitted.
  - Reset value 0.
- READ_DATA, after emitting the word:
  - Waits for `tx_valid`=1 and latches `tx_data`.
  - Drives bits 7..0 on MISO over the following 8 cycles.
  - Then holds MISO=0 until `SS_n`=1.
- `tx_valid` outside that wait window is ignored.
- `SS_n`=1 in any non-IDLE state -> IDLE on the next edge.
  - The partial word is discarded: counter cleared, no `rx_valid`, `rd_addr_ok` unchanged, MISO=0.
- Reset values: state IDLE, `rx_data`=0, `rx_valid`=0, MISO=0, `rd_addr_ok`=0, counter=0, out-shift register=0.
- `rst` takes priority over every input, including mid-frame and mid-readout.

## Timing
- Cycle numbering is relative to the first edge that sees `SS_n`=0 (cycle 0, IDLE).
- Cycles 1–10: bits 9..0 are sampled.
- Cycle 11: `rx_data` valid and `rx_valid`=1, for exactly one cycle.
- Read data, with the RAM answering one cycle later:
  - `tx_valid` is seen in cycle 12.
  - MISO carries bit 7 in cycle 13 through bit 0 in cycle 20, all registered outputs.
- Minimum `SS_n`-low time: 11 cycles for opcodes 00/01/10, 21 cycles for opcode 11.
- `SS_n` may rise in the same cycle as `rx_valid`; the word is still emitted.
- `SS_n` re-low immediately after IDLE re-entry starts a new frame with no extra gap.

## Configuration
- Macro: `SPI_RD_ADDR_CHECK_EN`.
- Defined:
  - An opcode-11 word arriving while `rd_addr_ok`=0 is dropped: no `rx_valid`, and no MISO readout.
  - An opcode-10 word arriving while `rd_addr_ok`=1 still updates the address normally.
- Undefined: every completed word is forwarded regardless of `rd_addr_ok`.
  - An opcode-11 frame reached through the READ_ADD path emits `rx_valid` but performs no MISO readout.

## Structure
- Package `spi_pkg` holds:
  - State encoding enum.
  - Opcode constants (`OP_WR_ADDR`, `OP_WR_DATA`, `OP_RD_ADDR`, `OP_RD_DATA`).
  - `WORD_W`/`DATA_W` defaults.
- A single flat module. The shift-in register, bit counter, out-shift register and FSM are small enough that no sub-module is warranted.

## Test plan
- Reset then frame 0x0FE (opcode 00) -> `rx_data`=0x0FE, `rx_valid` high only in cycle 11, MISO stays 0.
- Frame 0x1AA -> `rx_data`=0x1AA with a single `rx_valid`.
- Frame 0x2FE, then 0x3xx with the model RAM returning 0x5C -> `rd_addr_ok` set, then cleared; MISO = 0,1,0,1,1,1,0,0 over cycles 13–20.
- `SS_n` raised after 5 bits of 0x1AA -> no `rx_valid`, FSM in IDLE next cycle. A following full frame 0x155 is received correctly.
- Opcode-11 frame after reset:
  - With `SPI_RD_ADDR_CHECK_EN` -> no `rx_valid`, MISO 0.
  - Without it -> `rx_valid` with `rx_data[9:8]`=11.
- `rst`=1 during MISO readout at bit 4 -> MISO=0 and state IDLE next cycle; `rd_addr_ok`=0.
